// File: rtl/rgb_fade_sequencer_pkg.sv
// Shared definitions for the RGB fade sequencer: colour width, channel count
// and FSM state encoding.
package rgb_fade_sequencer_pkg;

  localparam int COLOR_W = 8;
  localparam int N_CH    = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } state_t;

endpackage

// File: rtl/rgb_fade_sequencer_ch.sv
// One colour channel of the fade sequencer: holds the current duty and the
// latched target, and moves the current duty toward the target by STEP on
// each tick without ever overshooting or wrapping.
module rgb_fade_sequencer_ch
  import rgb_fade_sequencer_pkg::*;
#(
  parameter int                 STEP      = 1,
  parameter logic [COLOR_W-1:0] RST_LEVEL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [COLOR_W-1:0] tgt_in_i,
  input  logic               tick_i,
  output logic [COLOR_W-1:0] cur_o,
  output logic               changed_o,
  // High when the channel is at its target, or will reach it on the next tick.
  output logic               at_tgt_o
);

  localparam logic [COLOR_W:0]   STEP_W = (COLOR_W+1)'(STEP);
  localparam logic [COLOR_W-1:0] STEP_N = COLOR_W'(STEP);

  logic [COLOR_W-1:0] cur_q, cur_d;
  logic [COLOR_W-1:0] tgt_q, tgt_d;
  logic [COLOR_W:0]   diff;
  logic               up;

  // Distance to target and the next duty value for this channel.
  always_comb begin
    up    = (tgt_q > cur_q);
    diff  = up ? ({1'b0, tgt_q} - {1'b0, cur_q}) : ({1'b0, cur_q} - {1'b0, tgt_q});
    tgt_d = load_i ? tgt_in_i : tgt_q;
    cur_d = cur_q;
    if (tick_i && (diff != '0)) begin
      if (diff <= STEP_W) cur_d = tgt_q;
      else if (up)        cur_d = cur_q + STEP_N;
      else                cur_d = cur_q - STEP_N;
    end
  end

  // Channel registers; reset discards any latched target.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= RST_LEVEL;
      tgt_q <= RST_LEVEL;
    end else begin
      cur_q <= cur_d;
      tgt_q <= tgt_d;
    end
  end

  assign cur_o     = cur_q;
  assign changed_o = tick_i && (diff != '0);
  assign at_tgt_o  = (diff <= STEP_W);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// RGB fade sequencer: accepts a target colour over valid/ready, ramps the three
// PWM duties toward it at one step per TICK_DIV cycles, and strobes value_en
// whenever the registered duties change.
module rgb_fade_sequencer
  import rgb_fade_sequencer_pkg::*;
#(
  parameter int                 TICK_DIV  = 1000,
  parameter int                 STEP      = 1,
  parameter logic [COLOR_W-1:0] RST_LEVEL = 8'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COLOR_W-1:0] tgt_r,
  input  logic [COLOR_W-1:0] tgt_g,
  input  logic [COLOR_W-1:0] tgt_b,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  output logic [COLOR_W-1:0] value_out0,
  output logic [COLOR_W-1:0] value_out1,
  output logic [COLOR_W-1:0] value_out2,
  output logic               value_en,
  output logic               busy,
  output logic               done
);

  localparam int             PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  LAST = PW'(TICK_DIV - 1);

  state_t                          state_q, state_d;
  logic [PW-1:0]                   presc_q, presc_d;
  logic                            en_q, en_d;
  logic                            done_q, done_d;
  logic                            init_q;

  logic [N_CH-1:0][COLOR_W-1:0]    tgt_in;
  logic [N_CH-1:0][COLOR_W-1:0]    cur;
  logic [N_CH-1:0]                 changed;
  logic [N_CH-1:0]                 at_tgt;
  logic                            accept;
  logic                            tick;

  assign tgt_in    = {tgt_b, tgt_g, tgt_r};
  assign tgt_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = tgt_ready && tgt_valid;
  assign tick      = (state_q == ST_FADE) && (presc_q == LAST);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    rgb_fade_sequencer_ch #(
      .STEP      (STEP),
      .RST_LEVEL (RST_LEVEL)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .load_i    (accept),
      .tgt_in_i  (tgt_in[c]),
      .tick_i    (tick),
      .cur_o     (cur[c]),
      .changed_o (changed[c]),
      .at_tgt_o  (at_tgt[c])
    );
  end

  // Next state, prescaler, and the strobes registered alongside the duties.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          presc_d = '0;
          // A target equal to the current colour completes without fading.
          if (tgt_in == cur) done_d  = 1'b1;
          else               state_d = ST_FADE;
        end
      end
      ST_FADE: begin
        if (tick) begin
          presc_d = '0;
          en_d    = |changed;
          if (&at_tgt) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; init_q requests one strobe after reset so the PWM picks up RST_LEVEL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      init_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      en_q    <= en_d;
      done_q  <= done_d;
      init_q  <= 1'b0;
    end
  end

  assign value_out0 = cur[0];
  assign value_out1 = cur[1];
  assign value_out2 = cur[2];
  assign value_en   = (en_q | init_q) & ~rst;
  assign done       = done_q & ~rst;
  assign busy       = (state_q == ST_FADE);

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer: two instances share the same stimulus, one with
// STEP=1 and one with STEP=100 (both TICK_DIV=4), each checked against a
// per-instance colour model.
module tb_rgb_fade_sequencer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tgt_valid = 1'b0;
  logic [7:0] tgt_r = '0, tgt_g = '0, tgt_b = '0;

  logic       ready [2];
  logic       en    [2];
  logic       busy  [2];
  logic       done  [2];
  logic [7:0] v0 [2];
  logic [7:0] v1 [2];
  logic [7:0] v2 [2];

  int total = 0;
  int bad   = 0;

  // Model state: current colour, latched target, fading flag, cycles since accept.
  int m_cur  [2][3];
  int m_tgt  [2][3];
  bit m_fade [2];
  int m_cnt  [2];
  bit m_en   [2];
  bit m_done [2];

  always #5 clk = ~clk;

  rgb_fade_sequencer #(.TICK_DIV(TD), .STEP(1), .RST_LEVEL(8'd0)) dut0 (
    .clk(clk), .rst(rst), .tgt_r(tgt_r), .tgt_g(tgt_g), .tgt_b(tgt_b),
    .tgt_valid(tgt_valid), .tgt_ready(ready[0]),
    .value_out0(v0[0]), .value_out1(v1[0]), .value_out2(v2[0]),
    .value_en(en[0]), .busy(busy[0]), .done(done[0]));

  rgb_fade_sequencer #(.TICK_DIV(TD), .STEP(100), .RST_LEVEL(8'd0)) dut1 (
    .clk(clk), .rst(rst), .tgt_r(tgt_r), .tgt_g(tgt_g), .tgt_b(tgt_b),
    .tgt_valid(tgt_valid), .tgt_ready(ready[1]),
    .value_out0(v0[1]), .value_out1(v1[1]), .value_out2(v2[1]),
    .value_en(en[1]), .busy(busy[1]), .done(done[1]));

  function automatic int step_of(int k);
    return (k == 0) ? 1 : 100;
  endfunction

  function automatic logic [27:0] obs(int k);
    return {ready[k], v0[k], v1[k], v2[k], en[k], busy[k], done[k]};
  endfunction

  function automatic logic [27:0] expw(int k);
    return {(!m_fade[k] && !rst), 8'(m_cur[k][0]), 8'(m_cur[k][1]), 8'(m_cur[k][2]),
            m_en[k], m_fade[k], m_done[k]};
  endfunction

  // Advance the colour model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int in_c [3];
    in_c[0] = tgt_r; in_c[1] = tgt_g; in_c[2] = tgt_b;
    for (int k = 0; k < 2; k++) begin
      m_en[k]   = 1'b0;
      m_done[k] = 1'b0;
      if (rst) begin
        for (int c = 0; c < 3; c++) m_cur[k][c] = 0;
        m_fade[k] = 1'b0;
        m_cnt[k]  = 0;
      end else if (!m_fade[k]) begin
        if (tgt_valid) begin
          if (in_c[0] == m_cur[k][0] && in_c[1] == m_cur[k][1] && in_c[2] == m_cur[k][2])
            m_done[k] = 1'b1;
          else begin
            m_fade[k] = 1'b1;
            m_cnt[k]  = 0;
            for (int c = 0; c < 3; c++) m_tgt[k][c] = in_c[c];
          end
        end
      end else begin
        m_cnt[k]++;
        if (m_cnt[k] == TD) begin
          bit all_eq;
          all_eq   = 1'b1;
          m_cnt[k] = 0;
          for (int c = 0; c < 3; c++) begin
            if (m_cur[k][c] < m_tgt[k][c]) begin
              m_cur[k][c] = (m_cur[k][c] + step_of(k) > m_tgt[k][c]) ? m_tgt[k][c] : m_cur[k][c] + step_of(k);
              m_en[k] = 1'b1;
            end else if (m_cur[k][c] > m_tgt[k][c]) begin
              m_cur[k][c] = (m_cur[k][c] - step_of(k) < m_tgt[k][c]) ? m_tgt[k][c] : m_cur[k][c] - step_of(k);
              m_en[k] = 1'b1;
            end
            if (m_cur[k][c] != m_tgt[k][c]) all_eq = 1'b0;
          end
          if (all_eq) begin
            m_done[k] = 1'b1;
            m_fade[k] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      edge_step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expw(k)) begin
          bad++; $display("FAIL reset dut%0d got=%h exp=%h", k, obs(k), expw(k));
        end
        total++;
        if ({ready[k], en[k], done[k], busy[k], v0[k]} !== 12'h000) begin
          bad++; $display("FAIL reset_const dut%0d got=%b%b%b%b/%0d exp=0000/0", k, ready[k], en[k], done[k], busy[k], v0[k]);
        end
      end
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({en[k], ready[k], v0[k], v1[k], v2[k]} !== {2'b11, 24'h0}) begin
        bad++; $display("FAIL rst_release dut%0d got en=%b rdy=%b v=%0d,%0d,%0d exp en=1 rdy=1 v=0,0,0",
                        k, en[k], ready[k], v0[k], v1[k], v2[k]);
      end
    end
    edge_step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== expw(k)) begin
        bad++; $display("FAIL rst_release_after dut%0d got=%h exp=%h", k, obs(k), expw(k));
      end
    end
  endtask

  // Fade to a target and record value_en pulses of one instance; compare every cycle.
  task automatic run_fade(input string name, input int r, input int g, input int b,
                          input int rec, output int pv [$], output int pc [$], output int pd [$]);
    pv = {}; pc = {}; pd = {};
    tgt_r = 8'(r); tgt_g = 8'(g); tgt_b = 8'(b); tgt_valid = 1'b1;
    edge_step();
    tgt_valid = 1'b0;
    for (int n = 1; n < 2000 && (m_fade[0] || m_fade[1]); n++) begin
      edge_step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expw(k)) begin
          bad++; $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", name, k, n, obs(k), expw(k));
        end
      end
      if (en[rec]) begin
        pv.push_back({v0[rec], v1[rec], v2[rec]});
        pc.push_back(n);
        pd.push_back(int'(done[rec]));
      end
    end
    total++;
    if (m_fade[0] || m_fade[1]) begin
      bad++; $display("FAIL %s_timeout got=busy exp=idle", name);
    end
  endtask

  task automatic test_basic_fade();
    int pv [$]; int pc [$]; int pd [$];
    run_fade("basic", 3, 0, 0, 0, pv, pc, pd);
    total++;
    if (pv.size() != 3) begin
      bad++; $display("FAIL basic_pulses got=%0d exp=3", pv.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (pv[i] != ((i + 1) << 16)) begin
          bad++; $display("FAIL basic_val%0d got=%h exp=%h", i, pv[i], (i + 1) << 16);
        end
      end
      total++;
      if (pc[1] - pc[0] != TD || pc[2] - pc[1] != TD || pc[0] != TD) begin
        bad++; $display("FAIL basic_spacing got=%0d,%0d,%0d exp=4,8,12", pc[0], pc[1], pc[2]);
      end
      total++;
      if (pd[0] != 0 || pd[1] != 0 || pd[2] != 1) begin
        bad++; $display("FAIL basic_done got=%0d%0d%0d exp=001", pd[0], pd[1], pd[2]);
      end
    end
  endtask

  task automatic test_saturation();
    int pv [$]; int pc [$]; int pd [$];
    int ex [3];
    ex[0] = {8'd100, 8'd155, 8'd50};
    ex[1] = {8'd200, 8'd55,  8'd50};
    ex[2] = {8'd255, 8'd0,   8'd50};
    run_fade("sat_pre", 0, 255, 50, 1, pv, pc, pd);
    run_fade("sat", 255, 0, 50, 1, pv, pc, pd);
    total++;
    if (pv.size() != 3) begin
      bad++; $display("FAIL sat_pulses got=%0d exp=3", pv.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (pv[i] != ex[i]) begin
          bad++; $display("FAIL sat_val%0d got=%h exp=%h", i, pv[i], ex[i]);
        end
      end
    end
  endtask

  task automatic test_null_fade();
    tgt_r = 8'd255; tgt_g = 8'd0; tgt_b = 8'd50; tgt_valid = 1'b1;
    edge_step();
    tgt_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({done[k], busy[k], en[k]} !== 3'b100) begin
        bad++; $display("FAIL null dut%0d got done/busy/en=%b%b%b exp=100", k, done[k], busy[k], en[k]);
      end
    end
    edge_step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== expw(k)) begin
        bad++; $display("FAIL null_after dut%0d got=%h exp=%h", k, obs(k), expw(k));
      end
    end
  endtask

  task automatic test_busy_ignore();
    tgt_r = 8'd250; tgt_g = 8'd10; tgt_b = 8'd60; tgt_valid = 1'b1;
    edge_step();
    tgt_r = 8'd0; tgt_g = 8'd0; tgt_b = 8'd0;
    for (int n = 1; n < 500 && (m_fade[0] || m_fade[1]); n++) begin
      if (n > 3) tgt_valid = 1'b0;
      edge_step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expw(k)) begin
          bad++; $display("FAIL busy_ign dut%0d cyc=%0d got=%h exp=%h", k, n, obs(k), expw(k));
        end
        if (n < 3) begin
          total++;
          if (ready[k] !== 1'b0) begin
            bad++; $display("FAIL busy_ready dut%0d got=%b exp=0", k, ready[k]);
          end
        end
      end
    end
    tgt_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({v0[k], v1[k], v2[k]} !== {8'd250, 8'd10, 8'd60}) begin
        bad++; $display("FAIL busy_final dut%0d got=%0d,%0d,%0d exp=250,10,60", k, v0[k], v1[k], v2[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    tgt_r = 8'd0; tgt_g = 8'd255; tgt_b = 8'd0; tgt_valid = 1'b1;
    edge_step();
    tgt_valid = 1'b0;
    repeat (2 * TD + 1) begin
      edge_step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expw(k)) begin
          bad++; $display("FAIL mid_fade dut%0d got=%h exp=%h", k, obs(k), expw(k));
        end
      end
    end
    rst = 1'b1;
    repeat (2) begin
      edge_step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({done[k], en[k], busy[k], v0[k], v1[k], v2[k]} !== 27'h0) begin
          bad++; $display("FAIL mid_rst dut%0d got done=%b en=%b busy=%b v=%0d,%0d,%0d exp all 0",
                          k, done[k], en[k], busy[k], v0[k], v1[k], v2[k]);
        end
      end
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({en[k], done[k]} !== 2'b10) begin
        bad++; $display("FAIL mid_rst_release dut%0d got en/done=%b%b exp=10", k, en[k], done[k]);
      end
    end
    repeat (2) begin
      edge_step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expw(k)) begin
          bad++; $display("FAIL mid_rst_idle dut%0d got=%h exp=%h", k, obs(k), expw(k));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      tgt_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        edge_step();
        for (int k = 0; k < 2; k++) begin
          total++;
          if (obs(k) !== expw(k)) begin
            bad++; $display("FAIL rnd_idle dut%0d it=%0d got=%h exp=%h", k, it, obs(k), expw(k));
          end
        end
      end
      tgt_r = 8'($urandom); tgt_g = 8'($urandom); tgt_b = 8'($urandom);
      tgt_valid = 1'b1;
      edge_step();
      for (int n = 1; n < 2000 && (m_fade[0] || m_fade[1]); n++) begin
        // Noise on the handshake only while both instances are fading.
        tgt_valid = (m_fade[0] && m_fade[1]) ? 1'($urandom) : 1'b0;
        tgt_r = 8'($urandom); tgt_g = 8'($urandom); tgt_b = 8'($urandom);
        edge_step();
        for (int k = 0; k < 2; k++) begin
          total++;
          if (obs(k) !== expw(k)) begin
            bad++; $display("FAIL rnd dut%0d it=%0d cyc=%0d got=%h exp=%h", k, it, n, obs(k), expw(k));
          end
        end
      end
      total++;
      if (m_fade[0] || m_fade[1]) begin
        bad++; $display("FAIL rnd_timeout it=%0d got=busy exp=idle", it);
      end
    end
    tgt_valid = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) begin m_cur[k][c] = 0; m_tgt[k][c] = 0; end
      m_fade[k] = 1'b0; m_cnt[k] = 0; m_en[k] = 1'b0; m_done[k] = 1'b0;
    end
    test_reset();
    test_basic_fade();
    test_saturation();
    test_null_fade();
    test_busy_ignore();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
